// File: rtl/gps_spi_pkg.sv
// Shared constants and FSM encoding for the GPS sample SPI receiver.
package gps_spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } rx_state_t;

  // Nibble fields within a received byte: sample 0 is sent first (high nibble).
  localparam int SAMPLE0_HI = 7;
  localparam int SAMPLE0_LO = 4;
  localparam int SAMPLE1_HI = 3;
  localparam int SAMPLE1_LO = 0;

  localparam int SPI_BITS  = 8;
  localparam int BIT_CNT_W = $clog2(SPI_BITS);

endpackage

// File: rtl/sample_byte_fifo.sv
// Small byte FIFO between the SPI deserializer and the nibble unpacker.
// A push while full is accepted only if a pop happens in the same cycle.
module sample_byte_fifo
  import gps_spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                gclk,
  input  logic                grst_n,
  input  logic                push,
  input  logic [SPI_BITS-1:0] push_data,
  input  logic                pop,
  output logic [SPI_BITS-1:0] head,
  output logic                full,
  output logic                empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SPI_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wptr;
  logic [AW:0]         rptr;
  logic                wr_en;
  logic                rd_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign head  = mem[rptr[AW-1:0]];

  // Storage: when full with a pop, the write lands in the slot being vacated.
  always_ff @(posedge gclk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= push_data;
  end

  // Read/write pointers.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + (AW+1)'(1);
      if (rd_en) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/gps_spi_sample_rx.sv
// SPI-slave receiver for the GPS sample stream. Oversamples the SPI pins on
// the MCU clock, deserializes bytes into a FIFO and unpacks each byte into
// two 4-bit samples on a valid/ready stream.
module gps_spi_sample_rx
  import gps_spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             MCU_CLK_25_000,
  input  logic             RESET_N,
  input  logic             MCU_SCK,
  input  logic             MCU_SS,
  input  logic             MCU_MOSI,
  output logic [3:0]       SAMPLE_DATA,
  output logic             SAMPLE_VALID,
  input  logic             SAMPLE_READY,
  output logic             FRAME_DONE,
  output logic [CNT_W-1:0] FRAME_BYTES,
  output logic             FRAME_ERR,
  output logic             OVERFLOW,
  input  logic             OVF_CLR
);

  logic sck_m, sck_s, sck_d;
  logic ss_m, ss_s;
  logic mosi_m, mosi_s;
  logic [1:0] warm;
  logic sck_rise;

  rx_state_t            state, state_nxt;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_nxt;
  logic [CNT_W-1:0]     byte_cnt, byte_nxt;
  logic [SPI_BITS-1:0]  shreg, shreg_nxt;
  logic                 push, done, err;

  logic [SPI_BITS-1:0]  head;
  logic                 full, empty;
  logic                 nib;
  logic                 accept, pop, drop;

  // Pin synchronizers. warm marks when the SS stage reflects the real pin
  // rather than its reset value, so a frame already in progress at reset
  // release is not mistaken for an idle bus.
  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      sck_m  <= 1'b0; sck_s  <= 1'b0; sck_d <= 1'b0;
      ss_m   <= 1'b1; ss_s   <= 1'b1;
      mosi_m <= 1'b0; mosi_s <= 1'b0;
      warm   <= 2'b00;
    end else begin
      sck_m  <= MCU_SCK;  sck_s  <= sck_m; sck_d <= sck_s;
      ss_m   <= MCU_SS;   ss_s   <= ss_m;
      mosi_m <= MCU_MOSI; mosi_s <= mosi_m;
      warm   <= {warm[0], 1'b1};
    end
  end

  assign sck_rise = sck_s & ~sck_d;

  // Frame FSM state register and counters.
  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= WAIT_IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_nxt;
      byte_cnt <= byte_nxt;
      shreg    <= shreg_nxt;
    end
  end

  // Next-state: shift on SCK rise first, then judge frame end on the
  // updated bit count so a coincident last-bit/SS rise ends cleanly.
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_cnt;
    shreg_nxt = shreg;
    push      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      WAIT_IDLE: if (warm[1] && ss_s) state_nxt = IDLE;
      IDLE: begin
        if (!ss_s) begin
          state_nxt = SHIFT;
          bit_nxt   = '0;
          byte_nxt  = '0;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          shreg_nxt = {shreg[SPI_BITS-2:0], mosi_s};
          if (bit_cnt == BIT_CNT_W'(SPI_BITS-1)) begin
            push    = 1'b1;
            bit_nxt = '0;
            if (byte_cnt != '1) byte_nxt = byte_cnt + CNT_W'(1);
          end else begin
            bit_nxt = bit_cnt + BIT_CNT_W'(1);
          end
        end
        if (ss_s) begin
          state_nxt = IDLE;
          if (bit_nxt == '0) done = 1'b1;
          else               err  = 1'b1;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  assign FRAME_DONE = done;
  assign FRAME_ERR  = err;

  // Byte count of the last cleanly ended frame.
  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N)  FRAME_BYTES <= '0;
    else if (done) FRAME_BYTES <= byte_nxt;
  end

  sample_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .gclk      (MCU_CLK_25_000),
    .grst_n    (RESET_N),
    .push      (push),
    .push_data (shreg_nxt),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Unpacker: nib=0 presents the high nibble, nib=1 the low nibble; the
  // byte leaves the FIFO when its low nibble is accepted.
  assign SAMPLE_VALID = ~empty;
  assign accept       = SAMPLE_VALID & SAMPLE_READY;
  assign pop          = accept & nib;
  assign drop         = push & full & ~pop;
  assign SAMPLE_DATA  = empty ? 4'h0 :
                        nib   ? head[SAMPLE1_HI:SAMPLE1_LO] : head[SAMPLE0_HI:SAMPLE0_LO];

  // Nibble-select flag toggles on every accepted sample.
  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N)    nib <= 1'b0;
    else if (accept) nib <= ~nib;
  end

  // Sticky overflow; a new drop wins over a same-cycle clear.
  always_ff @(posedge MCU_CLK_25_000 or negedge RESET_N) begin
    if (!RESET_N)     OVERFLOW <= 1'b0;
    else if (drop)    OVERFLOW <= 1'b1;
    else if (OVF_CLR) OVERFLOW <= 1'b0;
  end

endmodule

// File: tb/tb_gps_spi_sample_rx.sv
// Self-checking bench for gps_spi_sample_rx: random bytes and SCK timing,
// expected samples derived from the byte stream with a queue model.
module tb_gps_spi_sample_rx;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst_n, sck, ss, mosi, ready, ovf_clr;
  logic [3:0]       data;
  logic             valid, done, err, ovf;
  logic [CNT_W-1:0] fbytes;

  always #5 clk = ~clk;

  gps_spi_sample_rx #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .MCU_CLK_25_000 (clk),
    .RESET_N        (rst_n),
    .MCU_SCK        (sck),
    .MCU_SS         (ss),
    .MCU_MOSI       (mosi),
    .SAMPLE_DATA    (data),
    .SAMPLE_VALID   (valid),
    .SAMPLE_READY   (ready),
    .FRAME_DONE     (done),
    .FRAME_BYTES    (fbytes),
    .FRAME_ERR      (err),
    .OVERFLOW       (ovf),
    .OVF_CLR        (ovf_clr)
  );

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  logic [3:0] got[$];
  logic [3:0] exp_q[$];
  logic [7:0] tx[$];
  int         done_cnt = 0;
  int         err_cnt = 0;
  bit         rand_rdy = 1'b0;
  int         model_fbytes = 0;

  // Monitor: outputs are registered-derived, so mid-cycle sampling is stable.
  always @(negedge clk) begin
    #1;
    if (valid && ready) got.push_back(data);
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      if (rand_rdy) ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      tick(lo);
      sck = 1'b1;
      tick(hi);
      sck = 1'b0;
    end
  endtask

  task automatic send_frame(input int lo, input int hi);
    ss = 1'b0;
    tick(3);
    for (int i = 0; i < tx.size(); i++) spi_bits(tx[i], 8, lo, hi);
    tick(3);
    ss = 1'b1;
    tick(6);
  endtask

  // Reference: every kept byte yields its high nibble then its low nibble.
  task automatic model_byte(input logic [7:0] b);
    exp_q.push_back(b[7:4]);
    exp_q.push_back(b[3:0]);
  endtask

  task automatic drain();
    bit ok;
    rand_rdy = 1'b0;
    ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!valid) begin ok = 1'b1; break; end
      tick(1);
    end
    chk_cnt++;
    if (!ok) $display("FAIL drain_timeout: valid still %0b, required 0", valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0; ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    chk_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", valid); else pass_cnt++;
    chk_cnt++; if (data !== 4'h0) $display("FAIL reset_data: got %h exp 0", data); else pass_cnt++;
    chk_cnt++; if (fbytes !== '0) $display("FAIL reset_fbytes: got %0d exp 0", fbytes); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b exp 0", ovf); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("FAIL reset_err: got %b exp 0", err); else pass_cnt++;
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_basic();
    int s = got.size(); int d0 = done_cnt; int e0 = err_cnt;
    ready = 1'b1;
    tx = '{8'hA5, 8'h3C};
    exp_q = '{4'hA, 4'h5, 4'h3, 4'hC};
    send_frame(3, 2);
    drain();
    model_fbytes = 2;
    chk_cnt++; if (got.size() - s != 4) $display("FAIL basic_count: got %0d exp 4", got.size() - s); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (s + i >= got.size()) $display("FAIL basic_sample%0d: missing exp %h", i, exp_q[i]);
      else if (got[s+i] !== exp_q[i]) $display("FAIL basic_sample%0d: got %h exp %h", i, got[s+i], exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (done_cnt - d0 != 1) $display("FAIL basic_done: got %0d exp 1", done_cnt - d0); else pass_cnt++;
    chk_cnt++; if (err_cnt - e0 != 0) $display("FAIL basic_err: got %0d exp 0", err_cnt - e0); else pass_cnt++;
    chk_cnt++; if (fbytes !== CNT_W'(2)) $display("FAIL basic_fbytes: got %0d exp 2", fbytes); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int s = got.size(); int d0 = done_cnt;
      int nb = $urandom_range(1, 5);
      tx.delete(); exp_q.delete();
      for (int i = 0; i < nb; i++) begin
        tx.push_back(8'($urandom));
        model_byte(tx[i]);
      end
      rand_rdy = 1'b1;
      send_frame($urandom_range(2, 4), $urandom_range(2, 4));
      drain();
      model_fbytes = nb;
      chk_cnt++; if (got.size() - s != exp_q.size()) $display("FAIL rand%0d_count: got %0d exp %0d", f, got.size() - s, exp_q.size()); else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
        chk_cnt++;
        if (s + i >= got.size()) $display("FAIL rand%0d_sample%0d: missing exp %h", f, i, exp_q[i]);
        else if (got[s+i] !== exp_q[i]) $display("FAIL rand%0d_sample%0d: got %h exp %h", f, i, got[s+i], exp_q[i]);
        else pass_cnt++;
      end
      chk_cnt++; if (fbytes !== CNT_W'(model_fbytes)) $display("FAIL rand%0d_fbytes: got %0d exp %0d", f, fbytes, model_fbytes); else pass_cnt++;
      chk_cnt++; if (done_cnt - d0 != 1) $display("FAIL rand%0d_done: got %0d exp 1", f, done_cnt - d0); else pass_cnt++;
    end
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL rand_ovf: got %b exp 0", ovf); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int s = got.size(); int d0 = done_cnt; int e0 = err_cnt;
    logic [7:0] b = 8'($urandom);
    exp_q.delete(); model_byte(b);
    ready = 1'b1;
    ss = 1'b0; tick(3);
    spi_bits(b, 8, 2, 2);
    spi_bits(8'($urandom), 3, 2, 2);
    tick(3); ss = 1'b1; tick(6);
    drain();
    chk_cnt++; if (err_cnt - e0 != 1) $display("FAIL ferr_err: got %0d exp 1", err_cnt - e0); else pass_cnt++;
    chk_cnt++; if (done_cnt - d0 != 0) $display("FAIL ferr_done: got %0d exp 0", done_cnt - d0); else pass_cnt++;
    chk_cnt++; if (got.size() - s != 2) $display("FAIL ferr_count: got %0d exp 2", got.size() - s); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      chk_cnt++;
      if (s + i >= got.size()) $display("FAIL ferr_sample%0d: missing exp %h", i, exp_q[i]);
      else if (got[s+i] !== exp_q[i]) $display("FAIL ferr_sample%0d: got %h exp %h", i, got[s+i], exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (fbytes !== CNT_W'(model_fbytes)) $display("FAIL ferr_fbytes: got %0d exp %0d", fbytes, model_fbytes); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int s = got.size();
    ready = 1'b0; rand_rdy = 1'b0;
    tx.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      tx.push_back(8'($urandom));
      if (i < FIFO_DEPTH) model_byte(tx[i]);
    end
    send_frame(2, 2);
    model_fbytes = 6;
    chk_cnt++; if (valid !== 1'b1) $display("FAIL ovf_valid: got %b exp 1", valid); else pass_cnt++;
    chk_cnt++; if (data !== exp_q[0]) $display("FAIL ovf_stall_data: got %h exp %h", data, exp_q[0]); else pass_cnt++;
    chk_cnt++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b exp 1", ovf); else pass_cnt++;
    chk_cnt++; if (fbytes !== CNT_W'(6)) $display("FAIL ovf_fbytes: got %0d exp 6", fbytes); else pass_cnt++;
    ready = 1'b1;
    tick(8);
    chk_cnt++; if (valid !== 1'b0) $display("FAIL ovf_throughput: valid %b after 8 cycles, exp 0", valid); else pass_cnt++;
    drain();
    chk_cnt++; if (got.size() - s != 8) $display("FAIL ovf_count: got %0d exp 8", got.size() - s); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (s + i >= got.size()) $display("FAIL ovf_sample%0d: missing exp %h", i, exp_q[i]);
      else if (got[s+i] !== exp_q[i]) $display("FAIL ovf_sample%0d: got %h exp %h", i, got[s+i], exp_q[i]);
      else pass_cnt++;
    end
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; tick(1);
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL ovf_clr: got %b exp 0", ovf); else pass_cnt++;
  endtask

  task automatic test_full_pop();
    int s = got.size();
    ready = 1'b0; rand_rdy = 1'b0;
    tx.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      tx.push_back(8'($urandom));
      model_byte(tx[i]);
    end
    ss = 1'b0; tick(3);
    for (int i = 0; i < 4; i++) spi_bits(tx[i], 8, 2, 2);
    tick(4);
    ready = 1'b1; tick(1); ready = 1'b0;     // take the high nibble of the head
    spi_bits(tx[4], 7, 2, 2);
    mosi = tx[4][0];
    tick(2);
    sck = 1'b1;
    tick(2);                                 // now in the rise-detect cycle
    ready = 1'b1; tick(1); ready = 1'b0;     // low nibble pops as the byte pushes
    sck = 1'b0;
    tick(3); ss = 1'b1; tick(6);
    model_fbytes = 5;
    chk_cnt++; if (ovf !== 1'b0) $display("FAIL fullpop_ovf: got %b exp 0", ovf); else pass_cnt++;
    drain();
    chk_cnt++; if (got.size() - s != 10) $display("FAIL fullpop_count: got %0d exp 10", got.size() - s); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_cnt++;
      if (s + i >= got.size()) $display("FAIL fullpop_sample%0d: missing exp %h", i, exp_q[i]);
      else if (got[s+i] !== exp_q[i]) $display("FAIL fullpop_sample%0d: got %h exp %h", i, got[s+i], exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (fbytes !== CNT_W'(5)) $display("FAIL fullpop_fbytes: got %0d exp 5", fbytes); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int s = got.size(); int d0 = done_cnt; int e0 = err_cnt;
    ready = 1'b1; rand_rdy = 1'b0;
    ss = 1'b0; tick(3);
    spi_bits(8'($urandom), 4, 2, 2);
    rst_n = 1'b0; tick(2); rst_n = 1'b1;
    spi_bits(8'($urandom), 8, 2, 2);
    spi_bits(8'($urandom), 4, 2, 2);
    tick(3); ss = 1'b1; tick(6);
    model_fbytes = 0;
    chk_cnt++; if (got.size() - s != 0) $display("FAIL rmid_samples: got %0d exp 0", got.size() - s); else pass_cnt++;
    chk_cnt++; if (done_cnt - d0 != 0) $display("FAIL rmid_done: got %0d exp 0", done_cnt - d0); else pass_cnt++;
    chk_cnt++; if (err_cnt - e0 != 0) $display("FAIL rmid_err: got %0d exp 0", err_cnt - e0); else pass_cnt++;
    chk_cnt++; if (fbytes !== '0) $display("FAIL rmid_fbytes: got %0d exp 0", fbytes); else pass_cnt++;
    s = got.size(); d0 = done_cnt;
    tx = '{8'hFF};
    send_frame(2, 2);
    drain();
    chk_cnt++; if (got.size() - s != 2) $display("FAIL rmid_ff_count: got %0d exp 2", got.size() - s); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      chk_cnt++;
      if (s + i >= got.size()) $display("FAIL rmid_ff_sample%0d: missing exp f", i);
      else if (got[s+i] !== 4'hF) $display("FAIL rmid_ff_sample%0d: got %h exp f", i, got[s+i]);
      else pass_cnt++;
    end
    chk_cnt++; if (fbytes !== CNT_W'(1)) $display("FAIL rmid_ff_fbytes: got %0d exp 1", fbytes); else pass_cnt++;
    chk_cnt++; if (done_cnt - d0 != 1) $display("FAIL rmid_ff_done: got %0d exp 1", done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_coincident();
    int s = got.size(); int d0 = done_cnt; int e0 = err_cnt;
    logic [7:0] b = 8'($urandom);
    exp_q.delete(); model_byte(b);
    ready = 1'b1; rand_rdy = 1'b0;
    ss = 1'b0; tick(3);
    spi_bits(b, 7, 2, 2);
    mosi = b[0];
    tick(2);
    sck = 1'b1; ss = 1'b1;
    tick(2);
    sck = 1'b0;
    tick(6);
    drain();
    chk_cnt++; if (done_cnt - d0 != 1) $display("FAIL coinc_done: got %0d exp 1", done_cnt - d0); else pass_cnt++;
    chk_cnt++; if (err_cnt - e0 != 0) $display("FAIL coinc_err: got %0d exp 0", err_cnt - e0); else pass_cnt++;
    chk_cnt++; if (got.size() - s != 2) $display("FAIL coinc_count: got %0d exp 2", got.size() - s); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      chk_cnt++;
      if (s + i >= got.size()) $display("FAIL coinc_sample%0d: missing exp %h", i, exp_q[i]);
      else if (got[s+i] !== exp_q[i]) $display("FAIL coinc_sample%0d: got %h exp %h", i, got[s+i], exp_q[i]);
      else pass_cnt++;
    end
    chk_cnt++; if (fbytes !== CNT_W'(1)) $display("FAIL coinc_fbytes: got %0d exp 1", fbytes); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_frame_err();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_coincident();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/gps_spi_sample_rx.md
# gps_spi_sample_rx

SPI-slave receiver for the GPS sample stream: oversamples MCU_SCK/MCU_SS/MCU_MOSI on the 25 MHz MCU clock and deserializes bytes. Each byte carries two packed 2-bit I/Q samples. Bytes are buffered in a small FIFO and unpacked into a valid/ready stream of 4-bit samples, with per-frame byte count, frame-error and overflow reporting. It is the receiving end of the CPLD→MCU sample link and is used MCU-side and as the loopback checker in CPLD bring-up.

## Interface
- FIFO_DEPTH, 4: byte entries in buffer; power of 2, ≥2
- CNT_W, 16: width of frame byte counter
- MCU_CLK_25_000  in  1  sole clock, 25 MHz
- RESET_N  in  1  asynchronous, active-low reset
- MCU_SCK  in  1  SPI clock (mode 0, idles low), asynchronous to MCU_CLK_25_000
- MCU_SS  in  1  slave select, active-low, asynchronous
- MCU_MOSI  in  1  serial data, MSB first, asynchronous
- SAMPLE_DATA  out  4  {I1,I0,Q1,Q0} of head sample
- SAMPLE_VALID  out  1  SAMPLE_DATA holds a sample
- SAMPLE_READY  in  1  consumer accepts when VALID&READY
- FRAME_DONE  out  1  one-cycle pulse at clean frame end
- FRAME_BYTES  out  CNT_W  bytes received in last frame, held until next frame ends
- FRAME_ERR  out  1  one-cycle pulse: SS rose mid-byte
- OVERFLOW  out  1  sticky: a byte was dropped because FIFO full
- OVF_CLR  in  1  synchronous clear of OVERFLOW

## Operation
- 2-FF synchronizer per input; reset values SCK=0, SS=1, MOSI=0. Third SCK stage gives rise = sck_s & ~sck_d; ss_rise likewise on SS. MOSI sampled from its synced stage in the rise cycle.
- FSM, reset state WAIT_IDLE:
  - WAIT_IDLE: ignore all; go IDLE when synced SS=1 (prevents joining a frame mid-stream after reset).
  - IDLE: SS=0 → SHIFT; clear bit_cnt, byte_cnt.
  - SHIFT: on rise, shreg <= {shreg[6:0], mosi}, bit_cnt++. When 8th bit is shifted in: push byte, bit_cnt <= 0, byte_cnt++ (saturating at 2^CNT_W−1; dropped bytes still counted). On SS high: if bit_cnt==0, pulse FRAME_DONE and load FRAME_BYTES <= byte_cnt; else pulse FRAME_ERR, discard partial byte, leave FRAME_BYTES unchanged. → IDLE.
- SCK rise and SS rise detected in the same cycle: the bit is taken first, then the end-of-frame check uses the updated bit_cnt.
- Byte layout: bits[7:4] = sample 0, bits[3:0] = sample 1. Output presents the high nibble of the head byte, then the low nibble; the byte pops on acceptance of the low nibble.
- SAMPLE_VALID = FIFO not empty. SAMPLE_DATA is stable while VALID&~READY.
- Push when full: the byte is dropped and OVERFLOW is set. If the low nibble is popped in the same cycle, the push is accepted instead and no overflow occurs.
- OVERFLOW set and OVF_CLR in the same cycle: set wins.
- Reset values: SAMPLE_VALID=0, SAMPLE_DATA=0, FRAME_DONE=0, FRAME_BYTES=0, FRAME_ERR=0, OVERFLOW=0; FIFO empty. Reset asserted mid-frame aborts the frame without FRAME_ERR, and the FSM returns to WAIT_IDLE.

## Timing
- SCK high and low phases must each last ≥2 MCU clocks, so max SCK is 6.25 MHz. MOSI must be stable ≥2 MCU clocks around the SCK rise.
- Rise detect cycle D = 3rd MCU clock edge after the pin edge (±1 for synchronizer uncertainty).
- 8th-bit rise detected in D: byte is in the FIFO at the end of D, and SAMPLE_VALID=1 in D+1 if the FIFO was empty.
- SS pin rise → FRAME_DONE/FRAME_ERR pulse in cycle D of the SS rise.
- Full throughput: one sample per cycle when READY is held high.

## Structure
- Package gps_spi_pkg: FSM state encoding (WAIT_IDLE, IDLE, SHIFT), nibble field constants (SAMPLE0_HI=7, SAMPLE0_LO=4, SAMPLE1_HI=3, SAMPLE1_LO=0), SPI_BITS=8.
- Sub-module sample_byte_fifo: FIFO_DEPTH×8 synchronous FIFO with async active-low reset. Ports: push, push_data, pop, head, full, empty; simultaneous push/pop allowed when full.
- Top holds synchronizers, FSM, counters and the nibble-select flag.

## Test plan
- Frame of bytes 0xA5, 0x3C at 5 MHz SCK, READY=1 → samples 0xA, 0x5, 0x3, 0xC in order; FRAME_DONE once; FRAME_BYTES=2.
- SS rises after 11 bits → FRAME_ERR pulse; 1 byte delivered; FRAME_BYTES keeps its previous value.
- READY=0, frame of 6 bytes, FIFO_DEPTH=4 → first 4 bytes kept, OVERFLOW=1, FRAME_BYTES=6. Then READY=1 → exactly 8 samples out. OVF_CLR → OVERFLOW=0.
- FIFO full with the low nibble being accepted in the same cycle as the next byte push → no overflow, byte order preserved.
- RESET_N pulsed low mid-byte with SS held low, then released → no output until SS goes high. The next full frame of 0xFF yields samples 0xF, 0xF, FRAME_BYTES=1.
- SS rise coincident with the 8th SCK rise → FRAME_DONE (not FRAME_ERR), byte delivered.
